exc_commit_seq: RTL

//  Exception/ERET commit sequencer between the MEM-stage commit point and CP0.

---
 rtl/exc_commit_seq_if.sv | 54 +++++
 rtl/exc_commit_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/exc_commit_seq_if.sv
// -----------------------------------------------------------------------------
// exc_commit_seq_if
//   Bundles the signals between the MEM-stage commit point, CP0, fetch and
//   exc_commit_seq.
//   master : the pipeline/CP0/fetch side. It drives the MEM-stage request,
//            the CP0 status inputs and redirect_ready.
//   slave  : the sequencer. It drives the CP0 commit outputs, flush and the
//            redirect request.
//   MEM-stage request : mem_valid, mem_pc, mem_is_ds, mem_exc[6:0], mem_eret,
//                       mem_bad_addr, int_pending
//   CP0 inputs        : status_exl, cp0_epc_in
//   CP0 outputs       : cp0_commit, cp0_eret, cp0_exccode, cp0_epc, cp0_epc_we,
//                       cp0_bd, cp0_badv, cp0_badv_we
//   Pipeline control  : flush
//   Redirect          : redirect_valid, redirect_pc, redirect_ready
// -----------------------------------------------------------------------------
interface exc_commit_seq_if;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic        mem_is_ds;
    logic [6:0]  mem_exc;
    logic        mem_eret;
    logic [31:0] mem_bad_addr;
    logic        int_pending;
    logic        status_exl;
    logic [31:0] cp0_epc_in;
    logic        redirect_ready;

    logic        cp0_commit;
    logic        cp0_eret;
    logic [4:0]  cp0_exccode;
    logic [31:0] cp0_epc;
    logic        cp0_epc_we;
    logic        cp0_bd;
    logic [31:0] cp0_badv;
    logic        cp0_badv_we;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output mem_valid, mem_pc, mem_is_ds, mem_exc, mem_eret, mem_bad_addr,
               int_pending, status_exl, cp0_epc_in, redirect_ready,
        input  cp0_commit, cp0_eret, cp0_exccode, cp0_epc, cp0_epc_we, cp0_bd,
               cp0_badv, cp0_badv_we, flush, redirect_valid, redirect_pc
    );

    modport slave (
        input  mem_valid, mem_pc, mem_is_ds, mem_exc, mem_eret, mem_bad_addr,
               int_pending, status_exl, cp0_epc_in, redirect_ready,
        output cp0_commit, cp0_eret, cp0_exccode, cp0_epc, cp0_epc_we, cp0_bd,
               cp0_badv, cp0_badv_we, flush, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/exc_commit_seq.sv
// -----------------------------------------------------------------------------
// exc_commit_seq
//   Exception/ERET commit sequencer between the MEM-stage commit point and CP0.
//   When a request arrives in IDLE, the sequencer selects the highest-priority
//   cause and latches it. It then emits one commit (or eret) pulse to CP0,
//   keeps flush high for the commit cycle plus FLUSH_CYCLES cycles, and
//   finally offers the redirect PC to fetch until fetch accepts it. While a
//   sequence is in progress, any new request is dropped.
//
//   Parameters
//     FLUSH_CYCLES : number of cycles flush stays high after the commit cycle
//                    (must be >= 1)
//     EXC_VECTOR   : redirect target for every exception; an ERET redirects
//                    to EPC instead
//   Ports
//     clk, rst     : clock and asynchronous active-high reset
//     bus          : exc_commit_seq_if.slave (MEM request, CP0, flush, redirect)
//     exc_count    : number of exception commits (ERET is not counted); wraps
//                    at 2^32. This port exists only when the macro
//                    EXC_SEQ_CNT_EN is defined.
// -----------------------------------------------------------------------------
module exc_commit_seq #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] EXC_VECTOR   = 32'hbfc00380
) (
    input  logic        clk,
    input  logic        rst,
`ifdef EXC_SEQ_CNT_EN
    output logic [31:0] exc_count,
`endif
    exc_commit_seq_if.slave bus
);

    localparam int unsigned    CntW    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CntW-1:0] CntInit = CntW'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StCommit, StFlush, StRedirect} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic        trigger;
    logic        sel_eret;
    logic [4:0]  sel_code;
    logic [31:0] sel_badv;
    logic        sel_badv_we;

    logic        eret_q, eret_d;
    logic [4:0]  code_q, code_d;
    logic [31:0] epc_q, epc_d;
    logic        epc_we_q, epc_we_d;
    logic        bd_q, bd_d;
    logic [31:0] badv_q, badv_d;
    logic        badv_we_q, badv_we_d;
    logic [31:0] rpc_q, rpc_d;

    assign trigger = (state_q == StIdle) && bus.mem_valid &&
                     (bus.int_pending || (|bus.mem_exc) || bus.mem_eret);

    // Priority select. ERET is chosen only when no exception or interrupt is present.
    always_comb begin
        sel_eret    = 1'b0;
        sel_code    = 5'h00;
        sel_badv    = 32'h0;
        sel_badv_we = 1'b0;
        if (bus.int_pending) begin
            sel_badv = bus.mem_pc;
        end else if (bus.mem_exc[0]) begin
            sel_code    = 5'h04;
            sel_badv    = bus.mem_pc;
            sel_badv_we = 1'b1;
        end else if (bus.mem_exc[1]) begin
            sel_code = 5'h0a;
        end else if (bus.mem_exc[2]) begin
            sel_code = 5'h0c;
        end else if (bus.mem_exc[3]) begin
            sel_code = 5'h08;
        end else if (bus.mem_exc[4]) begin
            sel_code = 5'h09;
        end else if (bus.mem_exc[5]) begin
            sel_code    = 5'h04;
            sel_badv    = bus.mem_bad_addr;
            sel_badv_we = 1'b1;
        end else if (bus.mem_exc[6]) begin
            sel_code    = 5'h05;
            sel_badv    = bus.mem_bad_addr;
            sel_badv_we = 1'b1;
        end else begin
            sel_eret = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (trigger) state_d = StCommit;
            end
            StCommit: begin
                state_d = StFlush;
                cnt_d   = CntInit;
            end
            StFlush: begin
                if (cnt_q == '0) state_d = StRedirect;
                else             cnt_d   = cnt_q - CntW'(1);
            end
            StRedirect: begin
                if (bus.redirect_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        bus.cp0_commit     = 1'b0;
        bus.cp0_eret       = 1'b0;
        bus.flush          = 1'b0;
        bus.redirect_valid = 1'b0;
        unique case (state_q)
            StCommit: begin
                bus.cp0_commit = ~eret_q;
                bus.cp0_eret   = eret_q;
                bus.flush      = 1'b1;
            end
            StFlush:    bus.flush          = 1'b1;
            StRedirect: bus.redirect_valid = 1'b1;
            default: ;
        endcase
    end

    // Latched cause data. The ERET target is sampled during COMMIT, after CP0
    // has seen the request.
    always_comb begin
        eret_d    = eret_q;
        code_d    = code_q;
        epc_d     = epc_q;
        epc_we_d  = epc_we_q;
        bd_d      = bd_q;
        badv_d    = badv_q;
        badv_we_d = badv_we_q;
        rpc_d     = rpc_q;
        if (trigger) begin
            eret_d    = sel_eret;
            code_d    = sel_code;
            epc_d     = bus.mem_is_ds ? (bus.mem_pc - 32'd4) : bus.mem_pc;
            epc_we_d  = ~bus.status_exl;
            bd_d      = bus.mem_is_ds;
            badv_d    = sel_badv;
            badv_we_d = sel_badv_we;
        end
        if (state_q == StCommit) begin
            rpc_d = eret_q ? bus.cp0_epc_in : EXC_VECTOR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eret_q    <= 1'b0;
            code_q    <= 5'h00;
            epc_q     <= 32'h0;
            epc_we_q  <= 1'b0;
            bd_q      <= 1'b0;
            badv_q    <= 32'h0;
            badv_we_q <= 1'b0;
            rpc_q     <= 32'h0;
        end else begin
            eret_q    <= eret_d;
            code_q    <= code_d;
            epc_q     <= epc_d;
            epc_we_q  <= epc_we_d;
            bd_q      <= bd_d;
            badv_q    <= badv_d;
            badv_we_q <= badv_we_d;
            rpc_q     <= rpc_d;
        end
    end

    assign bus.cp0_exccode = code_q;
    assign bus.cp0_epc     = epc_q;
    assign bus.cp0_epc_we  = epc_we_q;
    assign bus.cp0_bd      = bd_q;
    assign bus.cp0_badv    = badv_q;
    assign bus.cp0_badv_we = badv_we_q;
    assign bus.redirect_pc = rpc_q;

`ifdef EXC_SEQ_CNT_EN
    logic [31:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (state_q == StCommit && !eret_q) count_d = count_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= 32'h0;
        else     count_q <= count_d;
    end

    assign exc_count = count_q;
`endif

endmodule
